// File: rtl/mostra_pkg.sv
// ----------------------------------------------------------------------------
// mostra_pkg: state encoding and debug codes shared by the sequence display.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mostra_pkg;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACENDE  = 3'd2,
        APAGA   = 3'd3,
        PROXIMO = 3'd4,
        FIM     = 3'd5
    } estado_t;

    localparam logic [3:0] DB_ERRO = 4'd9;

endpackage

`default_nettype wire

// File: rtl/contador_tempo.sv
// ----------------------------------------------------------------------------
// contador_tempo: up-counter with synchronous clear and terminal-count flag.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module contador_tempo #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               zera,
    input  logic               conta,
    input  logic [LARGURA-1:0] limite,
    output logic               fim
);

    logic [LARGURA-1:0] valor;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor <= '0;
        end else if (zera) begin
            valor <= '0;
        end else if (conta) begin
            valor <= valor + LARGURA'(1);
        end
    end

    assign fim = (valor == limite);

endmodule

`default_nettype wire

// File: rtl/unidade_mostra_sequencia.sv
// ----------------------------------------------------------------------------
// unidade_mostra_sequencia: plays the stored sequence onto the LEDs.
// MOSTRA_INTERVALO_EN adds a dark gap after each element. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module unidade_mostra_sequencia
    import mostra_pkg::*;
#(
    parameter int T_ACESO   = 50000000,
    parameter int T_APAGADO = 25000000,
    parameter int ADDR_W    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar_mostra,
    input  logic              cancela,
    input  logic [ADDR_W-1:0] limite,
    input  logic [3:0]        dado_memoria,
    output logic [ADDR_W-1:0] endereco,
    output logic [3:0]        leds,
    output logic              mostrando,
    output logic              pronto_mostra,
    output logic [3:0]        db_estado
);

    localparam int T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam int TW    = ($clog2(T_MAX) < 1) ? 1 : $clog2(T_MAX);
    localparam logic [TW-1:0] CMP_ACESO = TW'(T_ACESO - 1);
`ifdef MOSTRA_INTERVALO_EN
    localparam logic [TW-1:0] CMP_APAGADO = TW'(T_APAGADO - 1);
`endif

    estado_t           estado;
    estado_t           proximo;
    logic [ADDR_W-1:0] lim_r;
    logic [TW-1:0]     cmp;
    logic              zera;
    logic              conta;
    logic              fim_tempo;
    logic              abortar;
    logic              ultimo;

    assign abortar = cancela && (estado != OCIOSO);
    assign ultimo  = (endereco == lim_r);

    contador_tempo #(
        .LARGURA(TW)
    ) u_tempo (
        .clock (clock),
        .reset (reset),
        .zera  (zera),
        .conta (conta),
        .limite(cmp),
        .fim   (fim_tempo)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        conta   = 1'b0;
        zera    = 1'b1;
        cmp     = CMP_ACESO;
        case (estado)
            OCIOSO:  if (iniciar_mostra) proximo = CARREGA;
            CARREGA: proximo = ACENDE;
            ACENDE: begin
                conta = 1'b1;
                zera  = 1'b0;
                if (fim_tempo) begin
                    zera = 1'b1;
`ifdef MOSTRA_INTERVALO_EN
                    proximo = APAGA;
`else
                    proximo = ultimo ? FIM : PROXIMO;
`endif
                end
            end
`ifdef MOSTRA_INTERVALO_EN
            APAGA: begin
                conta = 1'b1;
                zera  = 1'b0;
                cmp   = CMP_APAGADO;
                if (fim_tempo) begin
                    zera    = 1'b1;
                    proximo = ultimo ? FIM : PROXIMO;
                end
            end
`endif
            PROXIMO: proximo = CARREGA;
            FIM:     proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
        // Abort wins over any transition the state itself would take.
        if (abortar) begin
            proximo = OCIOSO;
            zera    = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco <= '0;
            leds     <= '0;
            lim_r    <= '0;
        end else if (abortar) begin
            endereco <= '0;
            leds     <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    endereco <= '0;
                    leds     <= '0;
                    if (iniciar_mostra) lim_r <= limite;
                end
                CARREGA: leds <= dado_memoria;
                // Expiry goes dark whether or not a gap state follows.
                ACENDE:  if (fim_tempo) leds <= '0;
                PROXIMO: endereco <= endereco + ADDR_W'(1);
                FIM: begin
                    endereco <= '0;
                    leds     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign mostrando     = (estado != OCIOSO);
    assign pronto_mostra = (estado == FIM);

    always_comb begin
        db_estado = DB_ERRO;
        case (estado)
            OCIOSO:  db_estado = 4'd0;
            CARREGA: db_estado = 4'd1;
            ACENDE:  db_estado = 4'd2;
`ifdef MOSTRA_INTERVALO_EN
            APAGA:   db_estado = 4'd3;
`endif
            PROXIMO: db_estado = 4'd4;
            FIM:     db_estado = 4'd5;
            default: db_estado = DB_ERRO;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_unidade_mostra_sequencia.sv
// ----------------------------------------------------------------------------
// tb_unidade_mostra_sequencia: randomized bench against a timeline model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_unidade_mostra_sequencia;

    localparam int TA   = 3;
    localparam int TG   = 2;
    localparam int AW   = 3;
    localparam int NMEM = 8;
`ifdef MOSTRA_INTERVALO_EN
    localparam int GAP = TG;
`else
    localparam int GAP = 0;
`endif
    localparam int P = TA + GAP + 2;

    logic          clock   = 1'b0;
    logic          reset   = 1'b1;
    logic          iniciar = 1'b0;
    logic          cancela = 1'b0;
    logic [AW-1:0] limite  = '0;
    logic [3:0]    dado;
    logic [AW-1:0] endereco;
    logic [3:0]    leds;
    logic          mostrando;
    logic          pronto;
    logic [3:0]    db;
    logic [3:0]    mem [NMEM];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    assign dado = mem[endereco];

    unidade_mostra_sequencia #(
        .T_ACESO  (TA),
        .T_APAGADO(TG),
        .ADDR_W   (AW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar_mostra(iniciar),
        .cancela       (cancela),
        .limite        (limite),
        .dado_memoria  (dado),
        .endereco      (endereco),
        .leds          (leds),
        .mostrando     (mostrando),
        .pronto_mostra (pronto),
        .db_estado     (db)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Expected outputs in cycle c of a run started at edge 0: element i
    // occupies cycles i*P+1 .. (i+1)*P as load, lit, dark gap, then step/end.
    task automatic model(input int c, input int lim, input int cancel_at,
                         output logic [3:0] e_leds, output logic [AW-1:0] e_end,
                         output logic e_pr, output logic e_most, output logic [3:0] e_db);
        int i;
        int pos;
        e_leds = '0; e_end = '0; e_pr = 1'b0; e_most = 1'b0; e_db = 4'd0;
        if ((cancel_at == 0 || c <= cancel_at) && c >= 1 && c <= (lim + 1) * P) begin
            i      = (c - 1) / P;
            pos    = (c - 1) % P;
            e_most = 1'b1;
            e_end  = AW'(i);
            if (pos == 0) begin
                e_db = 4'd1;
            end else if (pos <= TA) begin
                e_db   = 4'd2;
                e_leds = mem[i];
            end else if (pos <= TA + GAP) begin
                e_db = 4'd3;
            end else begin
                e_db = (i == lim) ? 4'd5 : 4'd4;
                e_pr = (i == lim);
            end
        end
    endtask

    task automatic run(input int lim, input int cancel_at, input int lim_chg_at, input bit hold);
        logic [3:0]    el;
        logic [3:0]    ed;
        logic [AW-1:0] ee;
        logic          ep;
        logic          em;
        int            last;
        @(negedge clock);
        limite  = AW'(lim);
        iniciar = 1'b1;
        @(posedge clock);
        last = (cancel_at != 0) ? cancel_at + 1 : (lim + 1) * P + 1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clock);
            if (c == 1 && !hold) iniciar = 1'b0;
            model(c, lim, cancel_at, el, ee, ep, em, ed);
            check($sformatf("L%0d c%0d leds", lim, c), 32'(leds), 32'(el));
            check($sformatf("L%0d c%0d endereco", lim, c), 32'(endereco), 32'(ee));
            check($sformatf("L%0d c%0d pronto", lim, c), 32'(pronto), 32'(ep));
            check($sformatf("L%0d c%0d mostrando", lim, c), 32'(mostrando), 32'(em));
            check($sformatf("L%0d c%0d db_estado", lim, c), 32'(db), 32'(ed));
            cancela = (c == cancel_at);
            if (c == lim_chg_at) limite = '0;
        end
        cancela = 1'b0;
        if (hold) begin
            @(negedge clock);
            check("held start restarts", 32'(db), 32'd1);
            iniciar = 1'b0;
            cancela = 1'b1;
            @(negedge clock);
            cancela = 1'b0;
        end
        @(negedge clock);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lim;
        int cat;
        for (int k = 0; k < NMEM; k++) mem[k] = 4'(1 << (k % 4));
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        check("reset leds", 32'(leds), 32'd0);
        check("reset endereco", 32'(endereco), 32'd0);
        check("reset mostrando", 32'(mostrando), 32'd0);
        check("reset pronto", 32'(pronto), 32'd0);
        check("reset db_estado", 32'(db), 32'd0);
        reset = 1'b1;

        run(2, 0, 0, 1'b0);
        run(0, 0, 0, 1'b0);
        run(2, 10, 0, 1'b0);
        run(2, 0, 5, 1'b0);
        run(NMEM - 1, 0, 0, 1'b0);

        // Asynchronous reset in the middle of the first lit element.
        @(negedge clock);
        limite  = AW'(2);
        iniciar = 1'b1;
        @(posedge clock);
        @(negedge clock);
        iniciar = 1'b0;
        repeat (2) @(negedge clock);
        check("pre-reset leds", 32'(leds), 32'(mem[0]));
        #2 reset = 1'b0;
        #1;
        check("async reset leds", 32'(leds), 32'd0);
        check("async reset endereco", 32'(endereco), 32'd0);
        check("async reset mostrando", 32'(mostrando), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        run(2, 0, 0, 1'b0);

        run(1, 0, 0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < NMEM; k++) mem[k] = 4'($urandom);
            lim = int'($urandom_range(0, NMEM - 1));
            cat = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, (lim + 1) * P)) : 0;
            run(lim, cat, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
